regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  core clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 rf_rst_ready  in  1  regfile zeroing complete.
REQ-005 alu_valid/alu_ready  in/out  1/1  ALU write-back handshake; alu_sel in 5, alu_data in 32.
REQ-006 lsu_valid/lsu_ready  in/out  1/1  load-unit write-back handshake; lsu_sel in 5, lsu_data in 32.
REQ-007 dbg_valid/dbg_ready  in/out  1/1  debug write handshake; dbg_sel in 5, dbg_data in 32.
REQ-008 claim_en  in  1, claim_sel  in  5  mark destination register pending at issue.
REQ-009 chk_sel_1, chk_sel_2  in  5 each; chk_busy_1, chk_busy_2  out  1 each  pending status of queried registers.
REQ-010 rf_w_en  out  1, rf_w_sel  out  5, rf_w_data  out  32  registered regfile write port.
REQ-011 arb_ready  out  1  high in RUN state.

Function
REQ-012 SHALL implement two states: INIT (wait for regfile) and RUN.
REQ-013 INIT -> RUN on the first cycle rf_rst_ready is sampled high; RUN -> INIT whenever rf_rst_ready is sampled low.
REQ-014 In INIT all *_ready outputs, rf_w_en and arb_ready SHALL be 0, and the scoreboard SHALL be held cleared.
REQ-015 In RUN, each cycle at most one requester is granted; ready is combinational from valid and the arbitration state.
REQ-016 Priority: dbg highest; ALU and LSU share the port round-robin.
REQ-017 RR pointer favours ALU after reset; after an ALU grant it favours LSU, and after an LSU grant it favours ALU; a dbg grant leaves it unchanged.
REQ-018 A transfer occurs when valid and ready are both high at a rising edge; sel and data are sampled then.
REQ-019 Latency: a transfer at edge N drives rf_w_en=1, rf_w_sel and rf_w_data at the outputs from N to N+1; with no transfer, rf_w_en=0.
REQ-020 A transfer with sel=0 SHALL complete the handshake but drive rf_w_en=0 (x0 drop).
REQ-021 Scoreboard: 32-bit busy mask; claim_en sets busy[claim_sel]; an accepted ALU/LSU transfer clears busy[sel]; dbg transfers do not modify it.
REQ-022 A claim and a clear of the same register in one cycle SHALL leave the bit set (claim wins); different registers update independently.
REQ-023 busy[0] SHALL always read 0; chk_busy_x = busy[chk_sel_x], combinational.
REQ-024 Throughput: one write per cycle, sustained, with no bubbles between back-to-back transfers.

Reset
REQ-025 rst SHALL asynchronously force: state INIT, RR pointer to ALU, busy mask 0, rf_w_en 0, rf_w_sel 0, rf_w_data 0.
REQ-026 Reset during a pending request SHALL drop that request; requesters must hold valid until they see ready after RUN.

Configuration
REQ-027 Macro REGFILE_WB_ARB_SCOREBOARD_EN: when defined, the scoreboard is as in REQ-021..023.
REQ-028 When the macro is undefined, there SHALL be no busy storage, claim inputs are ignored, and chk_busy_1/2 are tied to 0; all other behaviour is unchanged.

Verification
REQ-029 Assert rst, hold rf_rst_ready=0 for 32 cycles with alu_valid=1 -> alu_ready=0 and rf_w_en=0 throughout; rf_rst_ready=1 -> arb_ready=1 the next cycle.
REQ-030 ALU and LSU both valid for 4 cycles (sel 5/6) -> grants ALU,LSU,ALU,LSU; rf_w_sel 5,6,5,6 one cycle later, with no gaps.
REQ-031 dbg, alu and lsu all valid at once -> dbg granted; the next ALU/LSU grant follows the RR pointer unchanged.
REQ-032 claim x7, then chk_sel_1=7 -> busy=1; LSU write x7 -> busy=0 the cycle after the transfer; claim x7 together with ALU write x7 -> busy stays 1.
REQ-033 ALU write sel=0 data 0xDEADBEEF -> alu_ready=1, rf_w_en stays 0; claim x0 -> chk_busy reads 0.
REQ-034 Drop rf_rst_ready mid-stream in RUN -> ready outputs 0 the same cycle, busy mask cleared, and state returns to INIT until rf_rst_ready rises again.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-back port arbiter for a 32 x 32-bit register file.
// Arbitrates the debug, ALU and load-unit writers onto a single registered
// write port. It waits in INIT until the register file reports zeroing
// complete. An optional pending-register scoreboard is built only when
// REGFILE_WB_ARB_SCOREBOARD_EN is defined. Without that macro there is no
// busy storage, the claim inputs are ignored, and chk_busy_1/2 read 0.
//
// Handshake: a requester raises *_valid and holds *_sel/*_data stable.
// A transfer happens on the rising edge where *_valid and *_ready are both
// high. *_ready is combinational from the valid inputs and the arbitration
// state, and it is only asserted for the requester granted that cycle.
// A request that has not yet seen ready may be dropped by reset or by
// rf_rst_ready falling. Requesters must keep valid high until they see ready.
module regfile_wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        rf_rst_ready,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_sel,
   input  logic [31:0] alu_data,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_sel,
   input  logic [31:0] lsu_data,
   input  logic        dbg_valid,
   output logic        dbg_ready,
   input  logic [4:0]  dbg_sel,
   input  logic [31:0] dbg_data,
   input  logic        claim_en,
   input  logic [4:0]  claim_sel,
   input  logic [4:0]  chk_sel_1,
   input  logic [4:0]  chk_sel_2,
   output logic        chk_busy_1,
   output logic        chk_busy_2,
   output logic        rf_w_en,
   output logic [4:0]  rf_w_sel,
   output logic [31:0] rf_w_data,
   output logic        arb_ready,
   output logic [0:0]  fsm_state
);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]  state_q, state_d;
   logic        rr_q, rr_d;            // 0: ALU favoured, 1: LSU favoured
   logic        grant_en;
   logic        gnt_dbg, gnt_alu, gnt_lsu, xfer;
   logic [4:0]  xfer_sel;
   logic [31:0] xfer_data;
   logic        rf_w_en_q, rf_w_en_d;
   logic [4:0]  rf_w_sel_q, rf_w_sel_d;
   logic [31:0] rf_w_data_q, rf_w_data_d;

   // Next state: RUN exactly while the register file reports ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: if (rf_rst_ready)  state_d = ST_RUN;
         ST_RUN:  if (!rf_rst_ready) state_d = ST_INIT;
         default: state_d = ST_INIT;
      endcase
   end

   // Grants are blocked the same cycle rf_rst_ready falls, before the state flips.
   assign grant_en = (state_q == ST_RUN) && rf_rst_ready;

   // Fixed priority for debug, round-robin between ALU and LSU.
   always_comb begin
      gnt_dbg = grant_en && dbg_valid;
      gnt_alu = grant_en && !dbg_valid && alu_valid && (!lsu_valid || !rr_q);
      gnt_lsu = grant_en && !dbg_valid && lsu_valid && (!alu_valid || rr_q);
   end

   assign dbg_ready = gnt_dbg;
   assign alu_ready = gnt_alu;
   assign lsu_ready = gnt_lsu;
   assign xfer      = gnt_dbg || gnt_alu || gnt_lsu;

   // Select the granted write and advance the round-robin pointer.
   always_comb begin
      xfer_sel  = 5'd0;
      xfer_data = 32'd0;
      rr_d      = rr_q;
      if (gnt_dbg) begin
         xfer_sel  = dbg_sel;
         xfer_data = dbg_data;
      end else if (gnt_alu) begin
         xfer_sel  = alu_sel;
         xfer_data = alu_data;
         rr_d      = 1'b1;
      end else if (gnt_lsu) begin
         xfer_sel  = lsu_sel;
         xfer_data = lsu_data;
         rr_d      = 1'b0;
      end
   end

   // Write port next values: writes to x0 complete the handshake but are dropped.
   always_comb begin
      rf_w_en_d   = xfer && (xfer_sel != 5'd0);
      rf_w_sel_d  = rf_w_sel_q;
      rf_w_data_d = rf_w_data_q;
      if (xfer) begin
         rf_w_sel_d  = xfer_sel;
         rf_w_data_d = xfer_data;
      end
   end

   // Control state and registered write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         rr_q        <= 1'b0;
         rf_w_en_q   <= 1'b0;
         rf_w_sel_q  <= 5'd0;
         rf_w_data_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         rf_w_en_q   <= rf_w_en_d;
         rf_w_sel_q  <= rf_w_sel_d;
         rf_w_data_q <= rf_w_data_d;
      end
   end

   assign rf_w_en   = rf_w_en_q;
   assign rf_w_sel  = rf_w_sel_q;
   assign rf_w_data = rf_w_data_q;
   assign arb_ready = (state_q == ST_RUN);
   assign fsm_state = state_q;

`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
   logic [31:0] busy_q, busy_d;
   logic [31:0] clr_mask, set_mask;

   // Busy mask update: clears from ALU/LSU writes, then claims (claim wins), x0 never busy.
   always_comb begin
      clr_mask = 32'd0;
      set_mask = 32'd0;
      if (gnt_alu) clr_mask[alu_sel] = 1'b1;
      if (gnt_lsu) clr_mask[lsu_sel] = 1'b1;
      if (claim_en) set_mask[claim_sel] = 1'b1;
      if (grant_en) busy_d = (busy_q & ~clr_mask) | set_mask;
      else          busy_d = 32'd0;
      busy_d[0] = 1'b0;
   end

   // Pending-register storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= 32'd0;
      else     busy_q <= busy_d;
   end

   assign chk_busy_1 = busy_q[chk_sel_1];
   assign chk_busy_2 = busy_q[chk_sel_2];
`else
   logic unused_claim;
   assign unused_claim = &{1'b0, claim_en, claim_sel, chk_sel_1, chk_sel_2};
   assign chk_busy_1   = 1'b0;
   assign chk_busy_2   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: bench for regfile_wb_arbiter.
// A reference model predicts the ready, busy and arb_ready values from the
// inputs. Each cycle it queues the expected write-port result, and that
// result is popped and compared after the clock edge. Scoreboard
// expectations follow REGFILE_WB_ARB_SCOREBOARD_EN in the same way as the
// design.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rf_rst_ready;
   logic        alu_valid, lsu_valid, dbg_valid;
   logic        alu_ready, lsu_ready, dbg_ready;
   logic [4:0]  alu_sel, lsu_sel, dbg_sel;
   logic [31:0] alu_data, lsu_data, dbg_data;
   logic        claim_en;
   logic [4:0]  claim_sel, chk_sel_1, chk_sel_2;
   logic        chk_busy_1, chk_busy_2;
   logic        rf_w_en;
   logic [4:0]  rf_w_sel;
   logic [31:0] rf_w_data;
   logic        arb_ready;
   logic [0:0]  fsm_state;

   int n_cmp = 0;
   int n_err = 0;

   logic [37:0] exp_q[$];   // {en, sel, data}

   logic        m_run;
   logic        m_rr;
   logic [31:0] m_busy;

   regfile_wb_arbiter dut (
      .clk(clk), .rst(rst), .rf_rst_ready(rf_rst_ready),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_sel(alu_sel), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_sel(lsu_sel), .lsu_data(lsu_data),
      .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
      .claim_en(claim_en), .claim_sel(claim_sel),
      .chk_sel_1(chk_sel_1), .chk_sel_2(chk_sel_2),
      .chk_busy_1(chk_busy_1), .chk_busy_2(chk_busy_2),
      .rf_w_en(rf_w_en), .rf_w_sel(rf_w_sel), .rf_w_data(rf_w_data),
      .arb_ready(arb_ready), .fsm_state(fsm_state)
   );

   // Clock generation.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run  = 1'b0;
      m_rr   = 1'b0;
      m_busy = 32'd0;
      exp_q.delete();
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_sel = 5'd0; alu_data = 32'd0;
      lsu_valid = 1'b0; lsu_sel = 5'd0; lsu_data = 32'd0;
      dbg_valid = 1'b0; dbg_sel = 5'd0; dbg_data = 32'd0;
      claim_en  = 1'b0; claim_sel = 5'd0;
      chk_sel_1 = 5'd0; chk_sel_2 = 5'd0;
   endtask

   // One clock cycle. Inputs are set at the preceding negedge. Checks the
   // combinational outputs, queues the expected write, advances the model
   // at the posedge, then checks the write port at the next negedge.
   task automatic step();
      logic        g_en, g_dbg, g_alu, g_lsu, g_any;
      logic [4:0]  s;
      logic [31:0] d;
      logic        n_run, n_rr;
      logic [31:0] n_busy;
      logic [37:0] exp_w;
`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
      logic [31:0] clr, set;
`endif
      #1;
      g_en  = m_run && rf_rst_ready;
      g_dbg = g_en && dbg_valid;
      g_alu = g_en && alu_valid && !dbg_valid && (!lsu_valid || !m_rr);
      g_lsu = g_en && lsu_valid && !dbg_valid && (!alu_valid || m_rr);
      g_any = g_dbg || g_alu || g_lsu;
      check_eq("arb_ready", {31'd0, arb_ready}, {31'd0, m_run});
      check_eq("dbg_ready", {31'd0, dbg_ready}, {31'd0, g_dbg});
      check_eq("alu_ready", {31'd0, alu_ready}, {31'd0, g_alu});
      check_eq("lsu_ready", {31'd0, lsu_ready}, {31'd0, g_lsu});
      check_eq("chk_busy_1", {31'd0, chk_busy_1}, {31'd0, m_busy[chk_sel_1]});
      check_eq("chk_busy_2", {31'd0, chk_busy_2}, {31'd0, m_busy[chk_sel_2]});
      s = 5'd0;
      d = 32'd0;
      if (g_dbg)      begin s = dbg_sel; d = dbg_data; end
      else if (g_alu) begin s = alu_sel; d = alu_data; end
      else if (g_lsu) begin s = lsu_sel; d = lsu_data; end
      if (g_any && (s != 5'd0)) exp_q.push_back({1'b1, s, d});
      else                      exp_q.push_back(38'd0);
      n_run = rf_rst_ready;
      n_rr  = m_rr;
      if (g_alu)      n_rr = 1'b1;
      else if (g_lsu) n_rr = 1'b0;
      n_busy = 32'd0;
`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
      if (g_en) begin
         clr = 32'd0;
         set = 32'd0;
         if (g_alu) clr[alu_sel] = 1'b1;
         if (g_lsu) clr[lsu_sel] = 1'b1;
         if (claim_en) set[claim_sel] = 1'b1;
         n_busy = (m_busy & ~clr) | set;
         n_busy[0] = 1'b0;
      end
`endif
      @(posedge clk);
      m_run  = n_run;
      m_rr   = n_rr;
      m_busy = n_busy;
      @(negedge clk);
      exp_w = exp_q.pop_front();
      check_eq("rf_w_en", {31'd0, rf_w_en}, {31'd0, exp_w[37]});
      if (exp_w[37]) begin
         check_eq("rf_w_sel", {27'd0, rf_w_sel}, {27'd0, exp_w[36:32]});
         check_eq("rf_w_data", rf_w_data, exp_w[31:0]);
      end
   endtask

   task automatic drive_random();
      alu_valid = ($urandom_range(0, 2) != 0);
      lsu_valid = ($urandom_range(0, 2) != 0);
      dbg_valid = ($urandom_range(0, 5) == 0);
      alu_sel   = 5'($urandom_range(0, 31));
      lsu_sel   = 5'($urandom_range(0, 31));
      dbg_sel   = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      lsu_data  = $urandom;
      dbg_data  = $urandom;
      claim_en  = ($urandom_range(0, 1) != 0);
      claim_sel = 5'($urandom_range(0, 31));
      chk_sel_1 = 5'($urandom_range(0, 31));
      chk_sel_2 = 5'($urandom_range(0, 31));
      rf_rst_ready = ($urandom_range(0, 19) != 0);
   endtask

   // Main stimulus sequence.
   initial begin
      logic [3:0] burst_alu_pat;
      logic [4:0] burst_sel;
      burst_alu_pat = 4'b0101;
      rst = 1'b1;
      rf_rst_ready = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      check_eq("rst_w_en",   {31'd0, rf_w_en}, 32'd0);
      check_eq("rst_w_sel",  {27'd0, rf_w_sel}, 32'd0);
      check_eq("rst_w_data", rf_w_data, 32'd0);
      check_eq("rst_arb",    {31'd0, arb_ready}, 32'd0);
      rst = 1'b0;

      // Held in INIT with a pending ALU request.
      alu_valid = 1'b1; alu_sel = 5'd3; alu_data = 32'h1234_5678;
      for (int i = 0; i < 32; i++) begin
         #1 check_eq("init_alu_ready", {31'd0, alu_ready}, 32'd0);
         step();
      end
      idle_inputs();
      rf_rst_ready = 1'b1;
      step();
      #1 check_eq("arb_up", {31'd0, arb_ready}, 32'd1);
      step();

      // ALU and LSU contend: strict alternation, no bubbles.
      alu_valid = 1'b1; alu_sel = 5'd5; alu_data = 32'hA000_0005;
      lsu_valid = 1'b1; lsu_sel = 5'd6; lsu_data = 32'hB000_0006;
      for (int i = 0; i < 4; i++) begin
         #1 check_eq("burst_alu_gnt", {31'd0, alu_ready}, {31'd0, burst_alu_pat[i]});
         step();
         burst_sel = (i % 2 == 0) ? 5'd5 : 5'd6;
         check_eq("burst_w_sel", {27'd0, rf_w_sel}, {27'd0, burst_sel});
         check_eq("burst_w_en", {31'd0, rf_w_en}, 32'd1);
      end

      // Debug wins; the round-robin pointer is left favouring ALU.
      dbg_valid = 1'b1; dbg_sel = 5'd9; dbg_data = 32'hD000_0009;
      #1 check_eq("dbg_gnt", {31'd0, dbg_ready}, 32'd1);
      step();
      dbg_valid = 1'b0;
      #1 check_eq("after_dbg_alu", {31'd0, alu_ready}, 32'd1);
      step();
      idle_inputs();

      // Scoreboard: claim, clear by LSU write, claim-wins collision.
      claim_en = 1'b1; claim_sel = 5'd7;
      step();
      claim_en = 1'b0; chk_sel_1 = 5'd7; chk_sel_2 = 5'd5;
      step();
      lsu_valid = 1'b1; lsu_sel = 5'd7; lsu_data = 32'h0000_0777;
      step();
      lsu_valid = 1'b0;
      step();
      claim_en = 1'b1; claim_sel = 5'd7;
      alu_valid = 1'b1; alu_sel = 5'd7; alu_data = 32'h7777_0000;
      step();
      claim_en = 1'b0; alu_valid = 1'b0;
      step();

      // Write to x0: handshake completes, no write; claim of x0 ignored.
      alu_valid = 1'b1; alu_sel = 5'd0; alu_data = 32'hDEAD_BEEF;
      claim_en = 1'b1; claim_sel = 5'd0; chk_sel_1 = 5'd0;
      #1 check_eq("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
      step();
      check_eq("x0_w_en", {31'd0, rf_w_en}, 32'd0);
      idle_inputs();
      chk_sel_1 = 5'd0;
      step();

      // rf_rst_ready falls mid-stream.
      claim_en = 1'b1; claim_sel = 5'd12;
      alu_valid = 1'b1; alu_sel = 5'd4; alu_data = 32'h0000_0044;
      lsu_valid = 1'b1; lsu_sel = 5'd8; lsu_data = 32'h0000_0088;
      step();
      rf_rst_ready = 1'b0; chk_sel_1 = 5'd12;
      #1 check_eq("drop_alu_ready", {31'd0, alu_ready}, 32'd0);
      check_eq("drop_lsu_ready", {31'd0, lsu_ready}, 32'd0);
      step();
      check_eq("drop_state", {31'd0, fsm_state}, 32'd0);
      step();
      rf_rst_ready = 1'b1;
      step();
      step();

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         drive_random();
         step();
      end

      // Asynchronous reset with a request pending.
      idle_inputs();
      rf_rst_ready = 1'b1;
      alu_valid = 1'b1; alu_sel = 5'd11; alu_data = 32'hCAFE_0011;
      #2 rst = 1'b1;
      #1 check_eq("arst_w_en", {31'd0, rf_w_en}, 32'd0);
      check_eq("arst_w_sel", {27'd0, rf_w_sel}, 32'd0);
      check_eq("arst_w_data", rf_w_data, 32'd0);
      check_eq("arst_arb", {31'd0, arb_ready}, 32'd0);
      check_eq("arst_alu_ready", {31'd0, alu_ready}, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step();
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
